balanced_decoder_stream: RTL and testbench

BALANCED_DECODER_STREAM -- requirements
Module: balanced_decoder_stream

---
 rtl/balanced_code_pkg.sv | 53 +++++
 rtl/balanced_sym_decode.sv | 55 +++++
 rtl/balanced_decoder_stream.sv | 135 +++++++++++++
 tb/tb_balanced_decoder_stream.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/balanced_code_pkg.sv
// Shared definitions for the 10b balanced-code stream decoder: weight tables,
// the IDLE control symbol and the word-alignment state type.
package balanced_code_pkg;

    typedef logic [4:0] half_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } lookup_t;

    typedef enum logic {
        HUNT,
        SYNC
    } sync_state_e;

    localparam logic [9:0] IDLE_SYM = 10'b1010000111;

    localparam half_t H3_TABLE [10] = '{
        5'b00111, 5'b01011, 5'b01101, 5'b01110, 5'b10011,
        5'b10101, 5'b10110, 5'b11001, 5'b11010, 5'b11100
    };

    localparam half_t H2_TABLE [10] = '{
        5'b00011, 5'b00101, 5'b00110, 5'b01010, 5'b01100,
        5'b01001, 5'b10001, 5'b10010, 5'b10100, 5'b11000
    };

    function automatic lookup_t find_h3(input half_t h);
        lookup_t r;
        r = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (H3_TABLE[i] == h) begin
                r.hit = 1'b1;
                r.idx = 4'(i);
            end
        end
        return r;
    endfunction

    function automatic lookup_t find_h2(input half_t h);
        lookup_t r;
        r = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (H2_TABLE[i] == h) begin
                r.hit = 1'b1;
                r.idx = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/balanced_sym_decode.sv
// Combinational decode of one 10-bit balanced symbol into a byte plus
// control and code-violation flags.
module balanced_sym_decode
    import balanced_code_pkg::*;
(
    input  logic [9:0] sym_i,
    output logic [7:0] byte_o,
    output logic       ctrl_o,
    output logic       err_o
);

    lookup_t    u_h3, l_h2, u_h2, l_h3;
    logic [3:0] a, b;

    always_comb begin
        u_h3   = find_h3(sym_i[9:5]);
        l_h2   = find_h2(sym_i[4:0]);
        u_h2   = find_h2(sym_i[9:5]);
        l_h3   = find_h3(sym_i[4:0]);
        a      = '0;
        b      = '0;
        byte_o = '0;
        ctrl_o = 1'b0;
        err_o  = 1'b0;
        // IDLE is checked first: its halves land in the upper/lower data
        // rows, but the stream treats it as the control fill symbol.
        if (sym_i == IDLE_SYM) begin
            ctrl_o = 1'b1;
        end else if (u_h3.hit && l_h2.hit) begin
            a = u_h3.idx;
            b = l_h2.idx;
            unique case ({a[3], b[3]})
                2'b00: byte_o = {2'b00, a[2:0], b[2:0]};
                2'b10: byte_o = {4'b1000, a[0], b[2:0]};
                2'b01: byte_o = {4'b1010, b[0], a[2:0]};
                2'b11: byte_o = {6'b111100, a[0], b[0]};
            endcase
        end else if (u_h2.hit && l_h3.hit) begin
            a = u_h2.idx;
            b = l_h3.idx;
            unique case ({a[3], b[3]})
                2'b00: byte_o = {2'b01, a[2:0], b[2:0]};
                2'b10: byte_o = {4'b1001, a[0], b[2:0]};
                2'b01: byte_o = {4'b1011, b[0], a[2:0]};
                2'b11: begin
                    byte_o = {6'b000000, a[0], b[0]};
                    ctrl_o = 1'b1;
                end
            endcase
        end else begin
            err_o = 1'b1;
        end
    end

endmodule

// File: rtl/balanced_decoder_stream.sv
// Multi-lane balanced-code stream decoder with word-level sync tracking,
// optional IDLE dropping, a one-deep output register and an error counter.
module balanced_decoder_stream
    import balanced_code_pkg::*;
#(
    parameter int unsigned lanes_p         = 2,
    parameter int unsigned sync_cnt_p      = 4,
    parameter int unsigned loss_cnt_p      = 3,
    parameter int unsigned drop_idle_p     = 1,
    parameter int unsigned err_cnt_width_p = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    input  logic [10*lanes_p-1:0]      data_i,
    output logic                       ready_o,
    output logic                       v_o,
    output logic [8*lanes_p-1:0]       data_o,
    output logic [lanes_p-1:0]         ctrl_o,
    output logic [lanes_p-1:0]         err_o,
    input  logic                       yumi_i,
    output logic                       synced_o,
    output logic [err_cnt_width_p-1:0] err_cnt_o,
    input  logic                       err_clear_i
);

    localparam int unsigned RUN_MAX = (sync_cnt_p > loss_cnt_p) ? sync_cnt_p : loss_cnt_p;
    localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);
    localparam logic [RUN_W-1:0] SYNC_CNT = RUN_W'(sync_cnt_p);
    localparam logic [RUN_W-1:0] LOSS_CNT = RUN_W'(loss_cnt_p);

    logic [8*lanes_p-1:0] dec_byte;
    logic [lanes_p-1:0]   dec_ctrl;
    logic [lanes_p-1:0]   dec_err;
    logic [lanes_p-1:0]   lane_idle;

    for (genvar k = 0; k < lanes_p; k++) begin : g_lane
        balanced_sym_decode u_dec (
            .sym_i  (data_i[10*k +: 10]),
            .byte_o (dec_byte[8*k +: 8]),
            .ctrl_o (dec_ctrl[k]),
            .err_o  (dec_err[k])
        );
        assign lane_idle[k] = (data_i[10*k +: 10] == IDLE_SYM);
    end

    sync_state_e      state_q, state_d;
    logic [RUN_W-1:0] good_run_q, good_run_d;
    logic [RUN_W-1:0] bad_run_q, bad_run_d;
    logic             accept, word_bad, all_idle, loss_hit, forward;

    assign ready_o  = ~v_o | yumi_i;
    assign accept   = v_i & ready_o;
    assign word_bad = |dec_err;
    assign all_idle = &lane_idle;
    assign loss_hit = word_bad && ((bad_run_q + RUN_W'(1)) == LOSS_CNT);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= HUNT;
            good_run_q <= '0;
            bad_run_q  <= '0;
        end else begin
            state_q    <= state_d;
            good_run_q <= good_run_d;
            bad_run_q  <= bad_run_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_run_d = good_run_q;
        bad_run_d  = bad_run_q;
        if (accept) begin
            unique case (state_q)
                HUNT: begin
                    if (word_bad) begin
                        good_run_d = '0;
                    end else if ((good_run_q + RUN_W'(1)) == SYNC_CNT) begin
                        state_d    = SYNC;
                        good_run_d = '0;
                        bad_run_d  = '0;
                    end else begin
                        good_run_d = good_run_q + RUN_W'(1);
                    end
                end
                SYNC: begin
                    if (loss_hit) begin
                        state_d    = HUNT;
                        good_run_d = '0;
                        bad_run_d  = '0;
                    end else if (word_bad) begin
                        bad_run_d = bad_run_q + RUN_W'(1);
                    end else begin
                        bad_run_d = '0;
                    end
                end
            endcase
        end
    end

    // The word that trips loss of sync is already treated as HUNT traffic.
    always_comb begin
        synced_o = (state_q == SYNC);
        forward  = accept && (state_q == SYNC) && !loss_hit
                   && !((drop_idle_p != 0) && all_idle);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_o    <= 1'b0;
            data_o <= '0;
            ctrl_o <= '0;
            err_o  <= '0;
        end else if (forward) begin
            v_o    <= 1'b1;
            data_o <= dec_byte;
            ctrl_o <= dec_ctrl;
            err_o  <= dec_err;
        end else if (yumi_i) begin
            v_o    <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_cnt_o <= '0;
        end else if (err_clear_i) begin
            err_cnt_o <= '0;
        end else if (accept && word_bad && !(&err_cnt_o)) begin
            err_cnt_o <= err_cnt_o + err_cnt_width_p'(1);
        end
    end

endmodule

// File: tb/tb_balanced_decoder_stream.sv
// Directed plus randomized checks of balanced_decoder_stream against a
// table-driven behavioural model of the symbol code and sync rules.
module tb_balanced_decoder_stream;

    localparam int LANES = 2;
    localparam int SYNCN = 4;
    localparam int LOSSN = 3;

    logic                 clk = 1'b0;
    logic                 reset_n_i, v_i, yumi_i, err_clear_i;
    logic [10*LANES-1:0]  data_i;
    logic                 ready_o, v_o, synced_o;
    logic [8*LANES-1:0]   data_o;
    logic [LANES-1:0]     ctrl_o, err_o;
    logic [15:0]          err_cnt_o;
    logic                 w2_ready, w2_v, w2_synced;
    logic [8*LANES-1:0]   w2_data;
    logic [LANES-1:0]     w2_ctrl, w2_err;
    logic [1:0]           w2_err_cnt;

    always #5 clk = ~clk;

    balanced_decoder_stream #(.lanes_p(LANES), .sync_cnt_p(SYNCN), .loss_cnt_p(LOSSN),
                              .drop_idle_p(1), .err_cnt_width_p(16)) dut (
        .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i),
        .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .ctrl_o(ctrl_o), .err_o(err_o),
        .yumi_i(yumi_i), .synced_o(synced_o), .err_cnt_o(err_cnt_o), .err_clear_i(err_clear_i)
    );

    balanced_decoder_stream #(.lanes_p(LANES), .sync_cnt_p(SYNCN), .loss_cnt_p(LOSSN),
                              .drop_idle_p(1), .err_cnt_width_p(2)) dut_w2 (
        .clk_i(clk), .reset_n_i(reset_n_i), .v_i(v_i), .data_i(data_i),
        .ready_o(w2_ready), .v_o(w2_v), .data_o(w2_data), .ctrl_o(w2_ctrl), .err_o(w2_err),
        .yumi_i(yumi_i), .synced_o(w2_synced), .err_cnt_o(w2_err_cnt), .err_clear_i(err_clear_i)
    );

    logic [4:0] h3 [10] = '{5'b00111, 5'b01011, 5'b01101, 5'b01110, 5'b10011,
                            5'b10101, 5'b10110, 5'b11001, 5'b11010, 5'b11100};
    logic [4:0] h2 [10] = '{5'b00011, 5'b00101, 5'b00110, 5'b01010, 5'b01100,
                            5'b01001, 5'b10001, 5'b10010, 5'b10100, 5'b11000};

    int errors = 0;
    int checks = 0;

    bit               m_sync, m_v;
    int               m_good, m_bad, m_errs;
    logic [15:0]      m_data;
    logic [LANES-1:0] m_ctrl, m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_in(input logic [4:0] h, input bit three);
        for (int i = 0; i < 10; i++)
            if ((three ? h3[i] : h2[i]) == h) return i;
        return -1;
    endfunction

    // Byte values computed arithmetically from the row/column rules.
    function automatic void ref_sym(input logic [9:0] s, output int byt, output bit c, output bit e);
        int ua, lb, ub, la;
        byt = 0; c = 0; e = 0;
        ua = idx_in(s[9:5], 1); lb = idx_in(s[4:0], 0);
        ub = idx_in(s[9:5], 0); la = idx_in(s[4:0], 1);
        if (s == 10'h287) c = 1;
        else if (ua >= 0 && lb >= 0) begin
            if (ua < 8 && lb < 8)       byt = ua * 8 + lb;
            else if (lb < 8)            byt = 128 + (ua - 8) * 8 + lb;
            else if (ua < 8)            byt = 160 + (lb - 8) * 8 + ua;
            else                        byt = 240 + (ua - 8) * 2 + (lb - 8);
        end else if (ub >= 0 && la >= 0) begin
            if (ub < 8 && la < 8)       byt = 64 + ub * 8 + la;
            else if (la < 8)            byt = 144 + (ub - 8) * 8 + la;
            else if (ub < 8)            byt = 176 + (la - 8) * 8 + ub;
            else begin c = 1;           byt = (ub - 8) * 2 + (la - 8); end
        end else e = 1;
    endfunction

    function automatic logic [9:0] rand_sym();
        int r;
        r = $urandom_range(0, 99);
        if (r < 60)      return {h3[$urandom_range(0, 9)], h2[$urandom_range(0, 9)]};
        else if (r < 80) return {h2[$urandom_range(0, 9)], h3[$urandom_range(0, 9)]};
        else if (r < 88) return 10'h287;
        else             return 10'($urandom);
    endfunction

    task automatic model_reset();
        m_sync = 0; m_v = 0; m_good = 0; m_bad = 0; m_errs = 0;
        m_data = '0; m_ctrl = '0; m_err = '0;
    endtask

    task automatic check_outputs();
        chk("v_o", v_o, m_v);
        chk("data_o", data_o, m_data);
        chk("ctrl_o", ctrl_o, m_ctrl);
        chk("err_o", err_o, m_err);
        chk("synced_o", synced_o, m_sync);
        chk("err_cnt_o", err_cnt_o, (m_errs > 65535) ? 65535 : m_errs);
        chk("w2_err_cnt", w2_err_cnt, (m_errs > 3) ? 3 : m_errs);
        chk("w2_v_o", w2_v, m_v);
    endtask

    task automatic step(input bit v, input logic [19:0] d, input bit y, input bit clr);
        bit y_eff, acc, bad, idle, fwd, c, e;
        int byt;
        logic [15:0] w_data;
        logic [LANES-1:0] w_ctrl, w_err;
        y_eff = y & m_v;
        v_i = v; data_i = d; yumi_i = y_eff; err_clear_i = clr;
        #1;
        chk("ready_o", ready_o, !m_v || y_eff);
        acc = v && (!m_v || y_eff);
        bad = 0; idle = 1;
        for (int k = 0; k < LANES; k++) begin
            ref_sym(d[10*k +: 10], byt, c, e);
            w_data[8*k +: 8] = 8'(byt);
            w_ctrl[k] = c; w_err[k] = e;
            bad |= e;
            idle &= (d[10*k +: 10] == 10'h287);
        end
        @(posedge clk);
        if (clr) m_errs = 0;
        else if (acc && bad) m_errs++;
        fwd = 0;
        if (acc) begin
            if (!m_sync) begin
                if (bad) m_good = 0;
                else begin
                    m_good++;
                    if (m_good == SYNCN) begin m_sync = 1; m_good = 0; m_bad = 0; end
                end
            end else if (bad) begin
                m_bad++;
                if (m_bad == LOSSN) begin m_sync = 0; m_good = 0; m_bad = 0; end
                else fwd = 1;
            end else begin
                m_bad = 0;
                fwd = !idle;
            end
        end
        if (fwd) begin m_v = 1; m_data = w_data; m_ctrl = w_ctrl; m_err = w_err; end
        else if (y_eff) m_v = 0;
        #1;
        check_outputs();
    endtask

    localparam logic [19:0] GOOD = {10'h0E3, 10'h0E3};
    localparam logic [19:0] BADW = {10'h0E3, 10'h3FF};
    localparam logic [19:0] IDLW = {10'h287, 10'h287};

    initial begin
        logic [15:0] held;
        model_reset();
        reset_n_i = 0; v_i = 0; yumi_i = 0; err_clear_i = 0; data_i = '0;
        #1;
        check_outputs();
        chk("reset_ready", ready_o, 1'b1);
        @(posedge clk); #1;
        reset_n_i = 1;

        // Acquire sync; the fifth word is the first forwarded one.
        for (int i = 0; i < 4; i++) step(1, GOOD, 0, 0);
        chk("sync_after_4", synced_o, 1'b1);
        chk("none_forwarded", v_o, 1'b0);
        step(1, GOOD, 0, 0);
        chk("fifth_fwd", {v_o, data_o}, {1'b1, 16'h0000});
        step(1, {10'h1A3, 10'h1A3}, 1, 0);
        chk("sym_1a3", data_o, 16'h1010);
        step(1, {10'h2AC, 10'h2AC}, 1, 0);
        chk("sym_2ac", data_o, 16'h2C2C);

        // Three bad words: two forwarded with err, sync lost on the third.
        step(1, BADW, 1, 0);
        chk("bad1_err", {v_o, err_o}, {1'b1, 2'b01});
        step(1, BADW, 1, 0);
        step(1, BADW, 1, 0);
        chk("loss_sync", synced_o, 1'b0);
        chk("err_cnt_3", err_cnt_o, 16'd3);

        // Resync, then IDLE dropping and mixed IDLE/data words.
        for (int i = 0; i < 4; i++) step(1, GOOD, 1, 0);
        step(1, IDLW, 1, 0);
        chk("idle_dropped", v_o, 1'b0);
        step(1, {10'h287, 10'h0E3}, 1, 0);
        chk("mixed_ctrl", {v_o, ctrl_o}, {1'b1, 2'b10});

        // Backpressure then back-to-back drain.
        step(1, {10'h1A3, 10'h0E3}, 0, 0);
        held = data_o;
        for (int i = 0; i < 5; i++) begin
            step(1, GOOD, 0, 0);
            chk("stall_ready", ready_o, 1'b0);
            chk("stall_hold", data_o, held);
        end
        for (int i = 0; i < 6; i++) begin
            step(1, {rand_sym() & 10'h000 | 10'h0E3, h3[i] == h3[i] ? {h3[i], h2[i]} : 10'h0}, 1, 0);
            chk("b2b_valid", v_o, m_v);
        end

        // Asynchronous reset with a held word.
        step(1, GOOD, 0, 0);
        v_i = 0; yumi_i = 0;
        #1 reset_n_i = 0;
        #1;
        model_reset();
        check_outputs();
        #1 reset_n_i = 1;
        #1 chk("ready_after_reset", ready_o, 1'b1);
        @(posedge clk); #1;

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, {rand_sym(), rand_sym()},
                 $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);

        // Saturation of the narrow counter and clear priority.
        step(0, GOOD, 1, 1);
        for (int i = 0; i < 5; i++) step(1, BADW, 1, 0);
        chk("w2_saturated", w2_err_cnt, 2'd3);
        chk("w16_count5", err_cnt_o, 16'd5);
        step(1, BADW, 1, 1);
        chk("clear_prio", {w2_err_cnt, err_cnt_o}, 18'd0);
        step(0, GOOD, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
